// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer.
// Holds the FSM state encoding and the hard-wired zero register index.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector.
// Flags a hazard when the load in EX writes a register that the instruction in ID reads.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] D_rs,
    input  logic [4:0] D_rt,
    input  logic       X_memRead,
    input  logic [4:0] X_writeReg,
    output logic       hazard
);

    // $0 is hard-wired, so a load targeting it never creates a dependency
    assign hazard = X_memRead && (X_writeReg != REG_ZERO) &&
                    ((X_writeReg == D_rs) || (X_writeReg == D_rt));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls, MEM-stage
// branch flushes and a timed data-memory handshake with a sticky error state.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  D_rs,
    input  logic [4:0]  D_rt,
    input  logic        X_memRead,
    input  logic [4:0]  X_writeReg,
    input  logic        M_branch,
    input  logic        M_zero,
    input  logic        M_memRead,
    input  logic        M_memWrite,
    input  logic        dmem_ready,
    output logic        dmem_req,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        memwb_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exmem_flush,
    output logic        memwb_flush,
    output logic        mem_err,
    output logic [15:0] stall_count
);

    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] WAIT_MAX  = '1;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic             load_use;
    logic             mem_access;
    logic             br_taken;
    logic             mem_busy;

    assign mem_access = M_memRead | M_memWrite;
    assign br_taken   = M_branch & M_zero;
    assign mem_busy   = (state == MEM_WAIT) || ((state == RUN) && mem_access);

    load_use_detect u_load_use (
        .D_rs      (D_rs),
        .D_rt      (D_rt),
        .X_memRead (X_memRead),
        .X_writeReg(X_writeReg),
        .hazard    (load_use)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            RUN: begin
                if (mem_access && !dmem_ready) begin
                    state_nxt    = (MEM_TIMEOUT == 1) ? ERR : MEM_WAIT;
                    wait_cnt_nxt = CNT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = '0;
                end else begin
                    if (wait_cnt == WAIT_LAST)
                        state_nxt = ERR;
                    if (wait_cnt != WAIT_MAX)
                        wait_cnt_nxt = wait_cnt + 1'b1;
                end
            end
            default: state_nxt = ERR;
        endcase
    end

    // Priority: reset > error > memory freeze > branch flush > load-use bubble
    always_comb begin
        dmem_req    = 1'b0;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        mem_err     = 1'b0;
        if (!rst) begin
            if (state != RUN && state != MEM_WAIT) begin
                {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b0;
                mem_err = 1'b1;
            end else begin
                dmem_req = mem_busy;
                if (mem_busy && !dmem_ready) begin
                    {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b0;
                    memwb_flush = 1'b1;
                end else if (br_taken) begin
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    exmem_flush = 1'b1;
                end else if (load_use) begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_count <= '0;
        else if (!pc_en && stall_count != 16'hFFFF)
            stall_count <= stall_count + 16'd1;
    end

endmodule
